trap_ctrl: RTL and testbench
============================

# trap_ctrl

Kernel-entry controller for the amber core, the counterpart of the SRET return path. It accepts trap requests (external IRQ, SYSCALL, illegal opcode), flushes the pipeline, writes the return address into LR through the special-register write port, and redirects fetch to a cause-indexed vector while setting kernel mode. A later SRET reads LR back as its branch target and leaves kernel mode. The block sits beside stg_ex; its branch and flush outputs are OR-ed into the existing redirect logic.

## Interface
- VEC_BASE, 48'h0000_0000_0100, address of vector 0
- VEC_STRIDE, 16, address distance between vectors
- iw_clk  in  1  clock
- iw_rst  in  1  synchronous, active-high reset
- iw_ex_valid  in  1  EX holds a real (non-bubble) instruction
- iw_pc  in  `HBIT_ADDR+1  PC of the instruction in EX
- iw_syscall  in  1  SYSCALL in EX this cycle (qualified by iw_ex_valid)
- iw_illegal  in  1  undecodable opcode in EX this cycle (qualified)
- iw_irq  in  1  level-sensitive external interrupt
- iw_sret  in  1  SRET retires from EX this cycle
- ow_flush  out  1  flush IF/ID/EX
- ow_stall  out  1  hold fetch
- ow_sr_we  out  1  special-register write enable
- ow_sr_idx  out  `HBIT_TGT_SR+1  always `SR_IDX_LR
- ow_sr_data  out  `HBIT_ADDR+1  return address
- ow_branch_taken  out  1  one-cycle redirect pulse
- ow_branch_pc  out  `HBIT_ADDR+1  vector address
- ow_cause  out  2  cause of the last accepted trap
- ow_kernel  out  1  kernel-mode flag
- ow_halt  out  1  double fault, core halted

## Operation
- Causes: 0 IRQ, 1 SYSCALL, 2 ILLEGAL, 3 DOUBLE.
- Priority on simultaneous requests: ILLEGAL > SYSCALL > IRQ.
- IRQ is accepted only when ow_kernel=0 and iw_ex_valid=1. SYSCALL and ILLEGAL are accepted only when iw_ex_valid=1.
- Return address:
  - SYSCALL: iw_pc+1, wrapping modulo 2^48.
  - ILLEGAL: iw_pc.
  - IRQ: iw_pc. The EX instruction is flushed and re-executed after return.
- SYSCALL or ILLEGAL while ow_kernel=1 is a double fault:
  - cause 3; LR is not written.
  - Branch to vector 3, then enter HALT.
  - HALT has ow_halt=1 and ow_stall=1, and is left only by reset.
- The return address and cause are latched at acceptance. Inputs are ignored while the FSM is busy.
- FSM states and transitions:
  - IDLE: on an accepted request go to FLUSH.
  - FLUSH: go to SAVE, or straight to BRANCH on a double fault.
  - SAVE: go to BRANCH.
  - BRANCH: go to IDLE, or to HALT on a double fault.
- ow_branch_pc = VEC_BASE + cause*VEC_STRIDE, computed at 48 bits with wrap.
- ow_kernel is set in BRANCH (non-double causes). It is cleared on iw_sret in IDLE.
- An IRQ asserted in the same cycle as iw_sret is not taken that cycle; it is taken the next cycle, after ow_kernel is 0.

## Timing
- Request sampled at edge N; the FSM enters FLUSH.
- Cycle N+1 (FLUSH): ow_flush=1, ow_stall=1.
- Cycle N+2 (SAVE): ow_sr_we=1, ow_sr_idx=`SR_IDX_LR, ow_sr_data=return address, ow_stall=1.
- Cycle N+3 (BRANCH): ow_branch_taken=1, ow_branch_pc valid, ow_stall=0. ow_kernel reads 1 from cycle N+4.
- Latency from request to redirect: 3 cycles (2 for a double fault).
- Reset values:
  - State IDLE; ow_flush, ow_stall, ow_sr_we, ow_branch_taken, ow_kernel, ow_halt all 0.
  - ow_cause 0, ow_branch_pc 0, ow_sr_data 0.
  - ow_sr_idx = `SR_IDX_LR.
- Reset asserted mid-sequence: the FSM returns to IDLE at that edge. No LR write or branch pulse follows.
- All outputs are registered.

## Structure
- Shared package header src/trap.vh holds:
  - `TRAP_IRQ, `TRAP_SYSCALL, `TRAP_ILLEGAL, `TRAP_DOUBLE
  - FSM state encodings
  - `SR_IDX_LR, added to src/sr.vh if not already present
- One sub-module, trap_prio: combinational priority encoder from (illegal, syscall, irq, kernel) to {accept, cause, double}.

## Test plan
- SYSCALL at iw_pc=48'h200, user mode -> flush at N+1; LR write of 48'h201 at N+2; branch to 48'h110 at N+3; ow_kernel=1, ow_cause=1.
- ILLEGAL and IRQ asserted together at iw_pc=48'h300 -> cause 2, LR=48'h300, branch to 48'h120; IRQ is not taken afterwards while ow_kernel=1.
- IRQ high in kernel mode, then iw_sret pulse -> no trap in the SRET cycle; trap starts the next cycle, cause 0, branch to 48'h100.
- SYSCALL while ow_kernel=1 -> no ow_sr_we; branch to 48'h130 at N+2; ow_halt=1 and ow_stall=1 held for 20 cycles.
- SYSCALL at iw_pc=48'hFFFF_FFFF_FFFF -> LR data 48'h0 (wrap).
- iw_rst asserted during SAVE -> no ow_sr_we and no branch pulse; all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared constants, cause codes and FSM encoding for the trap controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trap_ctrl_pkg;

  localparam int ADDR_W   = 48;
  localparam int SR_IDX_W = 4;

  // Special-register index of the link register.
  localparam logic [SR_IDX_W-1:0] SR_IDX_LR = 4'd1;

  localparam logic [ADDR_W-1:0] VEC_BASE   = 48'h0000_0000_0100;
  localparam logic [ADDR_W-1:0] VEC_STRIDE = 48'd16;

  localparam logic [1:0] TRAP_IRQ     = 2'd0;
  localparam logic [1:0] TRAP_SYSCALL = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
  localparam logic [1:0] TRAP_DOUBLE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_SAVE   = 3'd2,
    ST_BRANCH = 3'd3,
    ST_HALT   = 3'd4
  } trap_state_t;

  // Vector address for a cause; the product and sum wrap at 48 bits.
  function automatic logic [ADDR_W-1:0] vec_addr(input logic [1:0] cause);
    return VEC_BASE + (ADDR_W'(cause) * VEC_STRIDE);
  endfunction

endpackage

// File: rtl/trap_prio.sv
// trap_prio: priority encoder ILLEGAL > SYSCALL > IRQ; flags double faults taken in kernel mode.
// Latency: combinational.
// Backpressure: none; inputs must already be qualified by a valid EX instruction.
// Ports: illegal_i/syscall_i/irq_i qualified requests, kernel_i current mode;
//        accept_o request taken, cause_o trap cause, double_o SYSCALL/ILLEGAL in kernel mode.
module trap_prio
  import trap_ctrl_pkg::*;
(
  input  logic       illegal_i,
  input  logic       syscall_i,
  input  logic       irq_i,
  input  logic       kernel_i,
  output logic       accept_o,
  output logic [1:0] cause_o,
  output logic       double_o
);

  always_comb begin
    double_o = kernel_i & (illegal_i | syscall_i);
    // IRQ is masked in kernel mode; synchronous traps are never masked.
    accept_o = illegal_i | syscall_i | (irq_i & ~kernel_i);
    if (double_o) begin
      cause_o = TRAP_DOUBLE;
    end else if (illegal_i) begin
      cause_o = TRAP_ILLEGAL;
    end else if (syscall_i) begin
      cause_o = TRAP_SYSCALL;
    end else begin
      cause_o = TRAP_IRQ;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: kernel-entry controller; flush, save return address to LR, redirect to cause vector.
// Latency: request to redirect pulse 3 cycles (2 for a double fault); all outputs registered.
// Backpressure: requests are ignored while a sequence is in flight; HALT holds fetch until reset.
// Ports: iw_clk/iw_rst clock and sync active-high reset; iw_ex_valid/iw_pc/iw_syscall/iw_illegal/
//        iw_irq/iw_sret from EX; ow_flush/ow_stall/ow_branch_* into redirect logic;
//        ow_sr_* LR write port; ow_cause/ow_kernel/ow_halt status.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_ex_valid,
  input  logic [ADDR_W-1:0]   iw_pc,
  input  logic                iw_syscall,
  input  logic                iw_illegal,
  input  logic                iw_irq,
  input  logic                iw_sret,
  output logic                ow_flush,
  output logic                ow_stall,
  output logic                ow_sr_we,
  output logic [SR_IDX_W-1:0] ow_sr_idx,
  output logic [ADDR_W-1:0]   ow_sr_data,
  output logic                ow_branch_taken,
  output logic [ADDR_W-1:0]   ow_branch_pc,
  output logic [1:0]          ow_cause,
  output logic                ow_kernel,
  output logic                ow_halt
);

  trap_state_t       state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic              dbl_q, dbl_d;
  logic [ADDR_W-1:0] ret_q, ret_d;
  logic [ADDR_W-1:0] bpc_q, bpc_d;
  logic              kernel_q, kernel_d;
  logic              flush_q, flush_d;
  logic              stall_q, stall_d;
  logic              sr_we_q, sr_we_d;
  logic              br_q, br_d;
  logic              halt_q, halt_d;

  logic              p_accept;
  logic [1:0]        p_cause;
  logic              p_double;

  trap_prio u_prio (
    .illegal_i (iw_ex_valid & iw_illegal),
    .syscall_i (iw_ex_valid & iw_syscall),
    .irq_i     (iw_ex_valid & iw_irq),
    .kernel_i  (kernel_q),
    .accept_o  (p_accept),
    .cause_o   (p_cause),
    .double_o  (p_double)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    dbl_d    = dbl_q;
    ret_d    = ret_q;
    bpc_d    = bpc_q;
    kernel_d = kernel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (p_accept) begin
          state_d = ST_FLUSH;
          cause_d = p_cause;
          dbl_d   = p_double;
          // SYSCALL resumes after itself; IRQ/ILLEGAL re-execute the EX instruction.
          ret_d   = (p_cause == TRAP_SYSCALL) ? iw_pc + 48'd1 : iw_pc;
          bpc_d   = vec_addr(p_cause);
        end else if (iw_sret) begin
          kernel_d = 1'b0;
        end
      end
      ST_FLUSH:  state_d = dbl_q ? ST_BRANCH : ST_SAVE;
      ST_SAVE:   state_d = ST_BRANCH;
      ST_BRANCH: begin
        if (dbl_q) begin
          state_d = ST_HALT;
        end else begin
          state_d  = ST_IDLE;
          kernel_d = 1'b1;
        end
      end
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave a register.
    flush_d = (state_d == ST_FLUSH);
    stall_d = (state_d == ST_FLUSH) || (state_d == ST_SAVE) || (state_d == ST_HALT);
    sr_we_d = (state_d == ST_SAVE);
    br_d    = (state_d == ST_BRANCH);
    halt_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q  <= ST_IDLE;
      cause_q  <= TRAP_IRQ;
      dbl_q    <= 1'b0;
      ret_q    <= '0;
      bpc_q    <= '0;
      kernel_q <= 1'b0;
      flush_q  <= 1'b0;
      stall_q  <= 1'b0;
      sr_we_q  <= 1'b0;
      br_q     <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      dbl_q    <= dbl_d;
      ret_q    <= ret_d;
      bpc_q    <= bpc_d;
      kernel_q <= kernel_d;
      flush_q  <= flush_d;
      stall_q  <= stall_d;
      sr_we_q  <= sr_we_d;
      br_q     <= br_d;
      halt_q   <= halt_d;
    end
  end

  assign ow_flush        = flush_q;
  assign ow_stall        = stall_q;
  assign ow_sr_we        = sr_we_q;
  assign ow_sr_idx       = SR_IDX_LR;
  assign ow_sr_data      = ret_q;
  assign ow_branch_taken = br_q;
  assign ow_branch_pc    = bpc_q;
  assign ow_cause        = cause_q;
  assign ow_kernel       = kernel_q;
  assign ow_halt         = halt_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed test-plan scenarios plus randomized traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_trap_ctrl;
  import trap_ctrl_pkg::SR_IDX_LR;

  logic        iw_clk = 1'b0;
  logic        iw_rst;
  logic        iw_ex_valid;
  logic [47:0] iw_pc;
  logic        iw_syscall, iw_illegal, iw_irq, iw_sret;
  logic        ow_flush, ow_stall, ow_sr_we, ow_branch_taken, ow_kernel, ow_halt;
  logic [3:0]  ow_sr_idx;
  logic [47:0] ow_sr_data, ow_branch_pc;
  logic [1:0]  ow_cause;

  int tests = 0;
  int fails = 0;

  trap_ctrl dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_ex_valid(iw_ex_valid), .iw_pc(iw_pc),
    .iw_syscall(iw_syscall), .iw_illegal(iw_illegal), .iw_irq(iw_irq), .iw_sret(iw_sret),
    .ow_flush(ow_flush), .ow_stall(ow_stall), .ow_sr_we(ow_sr_we), .ow_sr_idx(ow_sr_idx),
    .ow_sr_data(ow_sr_data), .ow_branch_taken(ow_branch_taken), .ow_branch_pc(ow_branch_pc),
    .ow_cause(ow_cause), .ow_kernel(ow_kernel), .ow_halt(ow_halt)
  );

  always #5 iw_clk = ~iw_clk;

  // Reference model: an accepted trap expands into a list of per-cycle output expectations.
  typedef struct packed {
    logic fl; logic st; logic we; logic br; logic dbl;
  } ent_t;

  ent_t        q[$];
  ent_t        cur;
  logic        m_kernel, m_halt, m_idle, kset, hset;
  logic [1:0]  m_cause;
  logic [47:0] m_ret, m_bpc;

  function automatic ent_t mk(input logic fl, st, we, br, dbl);
    ent_t e;
    e.fl = fl; e.st = st; e.we = we; e.br = br; e.dbl = dbl;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cur = '0;
    m_kernel = 0; m_halt = 0; m_idle = 1; kset = 0; hset = 0;
    m_cause = 0; m_ret = 0; m_bpc = 0;
  endtask

  task automatic check_all();
    chk("flush",  64'(ow_flush),        64'(cur.fl));
    chk("stall",  64'(ow_stall),        64'(cur.st | m_halt));
    chk("sr_we",  64'(ow_sr_we),        64'(cur.we));
    chk("branch", 64'(ow_branch_taken), 64'(cur.br));
    chk("kernel", 64'(ow_kernel),       64'(m_kernel));
    chk("halt",   64'(ow_halt),         64'(m_halt));
    chk("cause",  64'(ow_cause),        64'(m_cause));
    chk("sr_idx", 64'(ow_sr_idx),       64'(SR_IDX_LR));
    if (cur.we) chk("sr_data", 64'(ow_sr_data), 64'(m_ret));
    if (cur.br) chk("branch_pc", 64'(ow_branch_pc), 64'(m_bpc));
  endtask

  task automatic do_reset();
    iw_rst = 1; iw_ex_valid = 0; iw_pc = 0;
    iw_syscall = 0; iw_illegal = 0; iw_irq = 0; iw_sret = 0;
    @(posedge iw_clk); #1;
    iw_rst = 0;
    model_reset();
    check_all();
    chk("rst_sr_data",   64'(ow_sr_data),   64'h0);
    chk("rst_branch_pc", 64'(ow_branch_pc), 64'h0);
  endtask

  // One clock cycle: drive inputs, let the model react, advance, compare.
  task automatic step(input logic v, input logic [47:0] pc,
                      input logic sc, input logic il, input logic irq, input logic sr);
    logic acc, dbl, kclr;
    logic [1:0] c;
    iw_ex_valid = v; iw_pc = pc; iw_syscall = sc; iw_illegal = il; iw_irq = irq; iw_sret = sr;
    kclr = 0;
    if (m_idle && !m_halt) begin
      dbl = v && (sc || il) && m_kernel;
      acc = v && (il || sc || (irq && !m_kernel));
      if (acc) begin
        c = dbl ? 2'd3 : il ? 2'd2 : sc ? 2'd1 : 2'd0;
        m_cause = c;
        m_bpc   = 48'h100 + {42'd0, c, 4'd0};
        m_ret   = (c == 2'd1) ? pc + 48'd1 : pc;
        q.push_back(mk(1, 1, 0, 0, dbl));
        if (!dbl) q.push_back(mk(0, 1, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 1, dbl));
      end else if (sr) begin
        kclr = 1;
      end
    end
    @(posedge iw_clk); #1;
    if (kset) m_kernel = 1;
    if (hset) m_halt = 1;
    if (kclr) m_kernel = 0;
    kset = 0; hset = 0;
    if (q.size() > 0) begin
      cur = q.pop_front();
      m_idle = 0;
      if (cur.br) begin
        if (cur.dbl) hset = 1; else kset = 1;
      end
    end else begin
      cur = '0;
      m_idle = 1;
    end
    check_all();
  endtask

  initial begin
    logic [63:0] r;
    model_reset();

    // SYSCALL in user mode at 0x200.
    do_reset();
    step(0, 48'h0, 0, 0, 0, 0);
    step(1, 48'h200, 1, 0, 0, 0);
    chk("sc_flush_n1", 64'(ow_flush), 64'h1);
    step(0, 48'h0, 0, 0, 0, 0);
    chk("sc_lr_we_n2", 64'(ow_sr_we), 64'h1);
    chk("sc_lr_data", 64'(ow_sr_data), 64'h201);
    step(0, 48'h0, 0, 0, 0, 0);
    chk("sc_branch_n3", 64'(ow_branch_taken), 64'h1);
    chk("sc_branch_pc", 64'(ow_branch_pc), 64'h110);
    step(0, 48'h0, 0, 0, 0, 0);
    chk("sc_kernel", 64'(ow_kernel), 64'h1);
    chk("sc_cause", 64'(ow_cause), 64'h1);

    // ILLEGAL and IRQ together: ILLEGAL wins, then IRQ stays masked in kernel mode.
    do_reset();
    step(1, 48'h300, 0, 1, 1, 0);
    step(1, 48'h300, 0, 0, 1, 0);
    chk("il_lr_data", 64'(ow_sr_data), 64'h300);
    step(1, 48'h304, 0, 0, 1, 0);
    chk("il_branch_pc", 64'(ow_branch_pc), 64'h120);
    chk("il_cause", 64'(ow_cause), 64'h2);
    for (int i = 0; i < 6; i++) step(1, 48'h400, 0, 0, 1, 0);
    chk("irq_masked", 64'(ow_flush), 64'h0);

    // IRQ held across SRET: not taken in the SRET cycle, taken the next.
    step(1, 48'h500, 0, 0, 1, 1);
    chk("sret_no_trap", 64'(ow_flush), 64'h0);
    chk("sret_user", 64'(ow_kernel), 64'h0);
    step(1, 48'h504, 0, 0, 1, 0);
    chk("irq_after_sret", 64'(ow_flush), 64'h1);
    step(1, 48'h504, 0, 0, 1, 0);
    step(1, 48'h504, 0, 0, 1, 0);
    chk("irq_branch_pc", 64'(ow_branch_pc), 64'h100);
    chk("irq_cause", 64'(ow_cause), 64'h0);
    step(0, 48'h0, 0, 0, 0, 0);

    // SYSCALL in kernel mode: double fault, then HALT.
    step(1, 48'h600, 1, 0, 0, 0);
    chk("dbl_flush", 64'(ow_flush), 64'h1);
    step(1, 48'h604, 1, 0, 0, 0);
    chk("dbl_branch_n2", 64'(ow_branch_taken), 64'h1);
    chk("dbl_no_we", 64'(ow_sr_we), 64'h0);
    chk("dbl_branch_pc", 64'(ow_branch_pc), 64'h130);
    for (int i = 0; i < 20; i++) begin
      step(1, 48'h700, 1, 1, 1, 1);
      chk("halt_held", 64'(ow_halt), 64'h1);
      chk("halt_stall", 64'(ow_stall), 64'h1);
    end

    // Return address wraps at 48 bits.
    do_reset();
    step(1, 48'hFFFF_FFFF_FFFF, 1, 0, 0, 0);
    step(0, 48'h0, 0, 0, 0, 0);
    chk("wrap_we", 64'(ow_sr_we), 64'h1);
    chk("wrap_data", 64'(ow_sr_data), 64'h0);
    step(0, 48'h0, 0, 0, 0, 0);
    step(0, 48'h0, 0, 0, 0, 0);

    // Reset asserted during SAVE aborts the sequence.
    do_reset();
    step(1, 48'h800, 1, 0, 0, 0);
    step(0, 48'h0, 0, 0, 0, 0);
    chk("save_reached", 64'(ow_sr_we), 64'h1);
    do_reset();
    chk("abort_kernel", 64'(ow_kernel), 64'h0);
    chk("abort_cause", 64'(ow_cause), 64'h0);
    for (int i = 0; i < 4; i++) step(0, 48'h0, 0, 0, 0, 0);

    // Randomized traffic; leave HALT via reset now and then.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_halt && $urandom_range(0, 7) == 0) begin
        do_reset();
      end else begin
        r = {$urandom(), $urandom()};
        step($urandom_range(0, 3) != 0, r[47:0],
             $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
